// File: rtl/reindeer_mm_reg_arbiter.sv
// Two-requester round-robin arbiter in front of the mm_reg Wishbone-style channel.
// One transaction in flight; registered ack/rdat back to the winner, error on timeout.
module reindeer_mm_reg_arbiter #(
    parameter int ADDR_BITS      = 16,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 sync_reset,

    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [XLEN/8-1:0]    m0_sel,
    input  logic [ADDR_BITS-1:0] m0_adr,
    input  logic [XLEN-1:0]      m0_wdat,
    output logic                 m0_ack,
    output logic                 m0_err,
    output logic [XLEN-1:0]      m0_rdat,

    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [XLEN/8-1:0]    m1_sel,
    input  logic [ADDR_BITS-1:0] m1_adr,
    input  logic [XLEN-1:0]      m1_wdat,
    output logic                 m1_ack,
    output logic                 m1_err,
    output logic [XLEN-1:0]      m1_rdat,

    output logic                 s_stb,
    output logic                 s_we,
    output logic [XLEN/8-1:0]    s_sel,
    output logic [ADDR_BITS-1:0] s_adr,
    output logic [XLEN-1:0]      s_wdat,
    input  logic [XLEN-1:0]      s_rdat,
    input  logic                 s_ack,

    output logic                 busy,
    output logic                 grant_id
);

    // state | meaning
    // IDLE  | no transaction; arbitrate among pending requests
    // BUSY  | strobe held to slave, waiting for s_ack or timeout
    // RESP  | one-cycle ack/err pulse visible to the winner

    localparam int SEL_BITS = XLEN / 8;
    localparam int CNT_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_BITS'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic                  last_grant;
    logic [CNT_BITS-1:0]   to_cnt;

    logic                  any_req;
    logic                  pick_m1;
    logic                  win_we;
    logic [SEL_BITS-1:0]   win_sel;
    logic [ADDR_BITS-1:0]  win_adr;
    logic [XLEN-1:0]       win_wdat;
    logic                  timed_out;

    // On a tie the requester that was not served last wins.
    always_comb begin
        any_req = m0_req | m1_req;
        pick_m1 = 1'b0;
        if (m0_req && m1_req) begin
            pick_m1 = ~last_grant;
        end else begin
            pick_m1 = m1_req;
        end
        win_we   = pick_m1 ? m1_we   : m0_we;
        win_sel  = pick_m1 ? m1_sel  : m0_sel;
        win_adr  = pick_m1 ? m1_adr  : m0_adr;
        win_wdat = pick_m1 ? m1_wdat : m0_wdat;
    end

    assign timed_out = TIMEOUT_EN && (to_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            to_cnt     <= '0;
            s_stb      <= 1'b0;
            s_we       <= 1'b0;
            s_sel      <= '0;
            s_adr      <= '0;
            s_wdat     <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdat    <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdat    <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        s_stb      <= 1'b1;
                        s_we       <= win_we;
                        s_sel      <= win_we ? win_sel : '1;
                        s_adr      <= win_adr;
                        s_wdat     <= win_wdat;
                        grant_id   <= pick_m1;
                        last_grant <= pick_m1;
                        busy       <= 1'b1;
                        to_cnt     <= '0;
                        state      <= BUSY;
                    end
                end

                BUSY: begin
                    if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    // A slave ack in the expiry cycle still completes cleanly.
                    if (s_ack) begin
                        s_stb <= 1'b0;
                        s_we  <= 1'b0;
                        if (grant_id) begin
                            m1_ack  <= 1'b1;
                            m1_err  <= 1'b0;
                            m1_rdat <= s_we ? '0 : s_rdat;
                        end else begin
                            m0_ack  <= 1'b1;
                            m0_err  <= 1'b0;
                            m0_rdat <= s_we ? '0 : s_rdat;
                        end
                        state <= RESP;
                    end else if (timed_out) begin
                        s_stb <= 1'b0;
                        if (grant_id) begin
                            m1_ack  <= 1'b1;
                            m1_err  <= 1'b1;
                            m1_rdat <= '0;
                        end else begin
                            m0_ack  <= 1'b1;
                            m0_err  <= 1'b1;
                            m0_rdat <= '0;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    m0_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_ack <= 1'b0;
                    m1_err <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reindeer_mm_reg_arbiter.sv
// Directed bench for reindeer_mm_reg_arbiter: vector table of single transactions
// plus hand-written contention and mid-transaction reset sequences.
module tb_reindeer_mm_reg_arbiter;

    logic        clk = 1'b0;
    logic        sync_reset = 1'b1;
    logic        m0_req = 0, m0_we = 0;
    logic [3:0]  m0_sel = 0;
    logic [15:0] m0_adr = 0;
    logic [31:0] m0_wdat = 0;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdat;
    logic        m1_req = 0, m1_we = 0;
    logic [3:0]  m1_sel = 0;
    logic [15:0] m1_adr = 0;
    logic [31:0] m1_wdat = 0;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdat;
    logic        s_stb, s_we;
    logic [3:0]  s_sel;
    logic [15:0] s_adr;
    logic [31:0] s_wdat;
    logic [31:0] s_rdat = 0;
    logic        s_ack = 0;
    logic        busy, grant_id;

    reindeer_mm_reg_arbiter #(
        .ADDR_BITS(16), .XLEN(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .sync_reset(sync_reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
        .m0_wdat(m0_wdat), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdat(m0_rdat),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
        .m1_wdat(m1_wdat), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdat(m1_rdat),
        .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
        .s_wdat(s_wdat), .s_rdat(s_rdat), .s_ack(s_ack),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        who;
        logic        we;
        logic [3:0]  sel;
        logic [15:0] adr;
        logic [31:0] wdat;
        int          delay;      // stb cycle index in which slave acks; >=8 never
        logic [31:0] srdat;
        logic [3:0]  exp_sel;
        int          exp_stb;
        logic        exp_err;
        logic [31:0] exp_rdat;
    } vec_t;

    vec_t        vecs[8];
    int          total = 0;
    int          bad = 0;
    int          cur_vec = -1;
    logic [31:0] exp_last[2] = '{32'h0, 32'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, cur_vec, act, exp);
        end
    endtask

    task automatic drive_req(input logic who, input logic req, input logic we,
                             input logic [3:0] sel, input logic [15:0] adr,
                             input logic [31:0] wdat);
        if (who) begin
            m1_req = req; m1_we = we; m1_sel = sel; m1_adr = adr; m1_wdat = wdat;
        end else begin
            m0_req = req; m0_we = we; m0_sel = sel; m0_adr = adr; m0_wdat = wdat;
        end
    endtask

    // Waits up to 4 cycles for s_stb; returns the number of cycles taken.
    task automatic wait_stb(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!s_stb && lat < 4);
    endtask

    task automatic run_txn(input vec_t v);
        int lat;
        int k;
        int nstb;
        drive_req(v.who, 1'b1, v.we, v.sel, v.adr, v.wdat);
        wait_stb(lat);
        chk("stb_latency", lat, 1);
        if (!s_stb) begin
            drive_req(v.who, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
            return;
        end
        chk("s_adr", s_adr, v.adr);
        chk("s_we", s_we, v.we);
        chk("s_sel", s_sel, v.exp_sel);
        chk("s_wdat", s_wdat, v.wdat);
        chk("grant_id", grant_id, v.who);
        chk("busy_in_busy", busy, 1);
        nstb = 0;
        k = 0;
        while (s_stb && k < 40) begin
            nstb++;
            s_ack  = (k == v.delay);
            s_rdat = (k == v.delay) ? v.srdat : 32'h0BAD0BAD;
            @(negedge clk);
            s_ack  = 1'b0;
            s_rdat = 32'h0BAD0BAD;
            k++;
        end
        chk("stb_cycles", nstb, v.exp_stb);
        chk("owner_ack", v.who ? m1_ack : m0_ack, 1);
        chk("owner_err", v.who ? m1_err : m0_err, v.exp_err);
        chk("owner_rdat", v.who ? m1_rdat : m0_rdat, v.exp_rdat);
        chk("other_ack", v.who ? m0_ack : m1_ack, 0);
        chk("other_rdat_hold", v.who ? m0_rdat : m1_rdat, exp_last[!v.who]);
        exp_last[v.who] = v.exp_rdat;
        drive_req(v.who, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        @(negedge clk);
        chk("idle_acks", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
        chk("idle_busy", busy, 0);
        chk("idle_stb", s_stb, 0);
    endtask

    initial begin
        int lat;
        logic exp_g;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 16'h0010, 32'h00000000, 2,  32'hDEADBEEF, 4'hF, 3, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 16'h0004, 32'h12345678, 0,  32'hAAAA5555, 4'h3, 1, 1'b0, 32'h00000000};
        vecs[2] = '{1'b1, 1'b0, 4'h5, 16'h0008, 32'h00000000, 1,  32'hCAFEF00D, 4'hF, 2, 1'b0, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1'b1, 4'hC, 16'h00FC, 32'h0BADC0DE, 3,  32'h5A5A5A5A, 4'hC, 4, 1'b0, 32'h00000000};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 16'h0020, 32'h00000000, 99, 32'h11111111, 4'hF, 8, 1'b1, 32'h00000000};
        vecs[5] = '{1'b1, 1'b0, 4'h1, 16'h0030, 32'h00000000, 7,  32'h76543210, 4'hF, 8, 1'b0, 32'h76543210};
        vecs[6] = '{1'b0, 1'b0, 4'hF, 16'hFFFF, 32'hFFFFFFFF, 0,  32'h00000001, 4'hF, 1, 1'b0, 32'h00000001};
        vecs[7] = '{1'b1, 1'b1, 4'h8, 16'h0044, 32'h89ABCDEF, 99, 32'h22222222, 4'h8, 8, 1'b1, 32'h00000000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stb", s_stb, 0);
        chk("rst_adr", s_adr, 0);
        chk("rst_sel", s_sel, 0);
        chk("rst_wdat", s_wdat, 0);
        chk("rst_flags", {s_we, m0_ack, m0_err, m1_ack, m1_err, busy, grant_id}, 0);
        chk("rst_m0_rdat", m0_rdat, 0);
        chk("rst_m1_rdat", m1_rdat, 0);
        sync_reset = 1'b0;

        // Contention: both held high, grants must alternate starting with m0
        drive_req(1'b0, 1'b1, 1'b1, 4'hF, 16'h0100, 32'h00000100);
        drive_req(1'b1, 1'b1, 1'b1, 4'hF, 16'h0200, 32'h00000200);
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 1);
            wait_stb(lat);
            chk("cont_stb", s_stb, 1);
            chk("cont_grant", grant_id, exp_g);
            chk("cont_adr", s_adr, exp_g ? 16'h0200 : 16'h0100);
            s_ack = 1'b1;
            @(negedge clk);
            s_ack = 1'b0;
            chk("cont_acks", {m1_ack, m0_ack}, exp_g ? 2'b10 : 2'b01);
        end
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        chk("cont_quiet", s_stb, 0);

        // Table of single transactions
        for (int i = 0; i < 8; i++) begin
            cur_vec = i;
            run_txn(vecs[i]);
        end
        cur_vec = -1;

        // Reset in the second stb cycle after granting m0
        drive_req(1'b0, 1'b1, 1'b0, 4'h0, 16'h0050, 32'h0);
        wait_stb(lat);
        chk("rb_stb", s_stb, 1);
        @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        chk("rb_stb_drop", s_stb, 0);
        chk("rb_no_ack", {m0_ack, m1_ack, busy}, 3'b000);
        m0_req = 1'b0;
        sync_reset = 1'b0;
        @(negedge clk);
        chk("rb_still_no_ack", {m0_ack, m1_ack, s_stb}, 3'b000);
        drive_req(1'b0, 1'b1, 1'b0, 4'h0, 16'h0060, 32'h0);
        drive_req(1'b1, 1'b1, 1'b0, 4'h0, 16'h0070, 32'h0);
        wait_stb(lat);
        chk("rb_tie_grant", grant_id, 0);
        chk("rb_tie_adr", s_adr, 16'h0060);
        s_ack  = 1'b1;
        s_rdat = 32'h600DF00D;
        @(negedge clk);
        s_ack  = 1'b0;
        chk("rb_acks", {m1_ack, m0_ack}, 2'b01);
        chk("rb_rdat", m0_rdat, 32'h600DF00D);
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reindeer_mm_reg_arbiter.md
Name: reindeer_mm_reg_arbiter

Overview:
- Two-requester arbiter and sequencer for the memory-mapped register bus. It sits in front of the mm_reg block's Wishbone-style read/write channel.
- Requester 0 is the core data port; requester 1 is the debug/DMA port.
- Serialises one transaction at a time with round-robin fairness and holds strobe until the slave acks.
- Returns a registered ack/read-data pulse to the winning requester, and aborts with an error after a programmable timeout.

Parameters:
- ADDR_BITS, 16, register address width.
- XLEN, 32, data width. Byte-select width is XLEN/8.
- TIMEOUT_CYCLES, 255, number of BUSY cycles without slave ack before abort. 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- sync_reset  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 transaction request. Level signal, held until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_sel  in  XLEN/8  byte enables, writes only.
- m0_adr  in  ADDR_BITS  register address.
- m0_wdat  in  XLEN  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  qualifies m0_ack: transaction timed out.
- m0_rdat  out  XLEN  read data, valid with m0_ack.
- m1_req, m1_we, m1_sel, m1_adr, m1_wdat, m1_ack, m1_err, m1_rdat: same as requester 0, for requester 1.
- s_stb  out  1  slave strobe.
- s_we  out  1  slave write enable.
- s_sel  out  XLEN/8  slave byte select.
- s_adr  out  ADDR_BITS  slave address.
- s_wdat  out  XLEN  slave write data.
- s_rdat  in  XLEN  slave read data.
- s_ack  in  1  slave acknowledge.
- busy  out  1  high in BUSY and RESP.
- grant_id  out  1  requester currently or last served.

Behaviour:
- Reset (sync_reset high at a clk edge): next state IDLE. All outputs go to 0: s_*, mN_ack, mN_err, mN_rdat, busy, grant_id. last_grant is set to 1, so m0 wins the first tie. Timeout counter is cleared.
- Reset mid-transaction: the transaction is dropped. No ack is issued, and s_stb is low on the next cycle.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant that requester.
- IDLE, both requesting: grant the requester that is not last_grant.
- IDLE, on grant: latch the winner's we/sel/adr/wdat into the s_* registers, set grant_id and last_grant, assert s_stb, go to BUSY.
- IDLE, read command: s_sel is driven as all-ones.
- BUSY: s_stb and the command are held stable. The timeout counter increments each cycle.
- BUSY, s_ack high: capture s_rdat (0 for writes) into the granted mN_rdat, pulse the granted mN_ack, clear s_stb and s_we, go to RESP.
- BUSY, timeout (counter reaches TIMEOUT_CYCLES - 1 with no s_ack, TIMEOUT_CYCLES ≠ 0): clear s_stb, pulse mN_ack with mN_err=1 and mN_rdat=0, go to RESP.
- BUSY, s_ack in the same cycle as timeout: s_ack wins, err=0.
- RESP: one cycle. mN_ack/mN_err are visible to the requester. Requests are ignored. Then go to IDLE and clear mN_ack/mN_err. mN_rdat holds until the next completion for that requester.
- Requester rule: drop req in the cycle after it sees ack. A req still high in IDLE is treated as a new transaction.
- Latency: req in IDLE at cycle 0 → s_stb at 1. s_ack at cycle n → mN_ack at n+1, IDLE at n+2. Minimum turnaround is 3 cycles.
- s_ack while not in BUSY is ignored.
- The non-granted requester never sees ack. Its inputs are not sampled until it wins.
- Timeout counter width is ceil(log2(TIMEOUT_CYCLES+1)). It clears on entry to BUSY and cannot wrap.
- Fairness: with both requests held continuously, grants strictly alternate 0,1,0,1...

Test Plan:
- Single read: m0 reads adr 0x0010; slave acks 2 cycles after s_stb with s_rdat=0xDEADBEEF → s_stb high for exactly 3 cycles, s_adr=0x0010, s_we=0. m0_ack pulses 1 cycle after s_ack with m0_rdat=0xDEADBEEF, m0_err=0.
- Write with byte select: m1 writes adr 0x0004, sel=4'b0011, wdat=0x12345678; slave acks in the first stb cycle → s_we=1, s_sel=0011, s_wdat=0x12345678. m1_ack at cycle 2, IDLE at cycle 3.
- Contention: m0 and m1 both raise req on the cycle after reset and re-request immediately after each ack, 4 transactions → grant order 0,1,0,1. Each ack goes only to its owner.
- Timeout: TIMEOUT_CYCLES=8, slave never acks → s_stb high 8 cycles then low. Ack pulse with err=1, rdat=0. Next request is accepted normally.
- Ack/timeout race: s_ack arrives in the same cycle the counter expires → err=0 and rdat = s_rdat.
- Reset mid-BUSY: sync_reset asserted on the 2nd stb cycle → s_stb=0 next cycle, no mN_ack. After reset, m0 wins a tie.
